score_init_sequencer: RTL

Upstream sequencer for the score-RAM write stage. On `start` it walks the first row, then the first column, of the (N+1)×(N+1) Needleman-Wunsch score matrix. Each step emits one registered initialisation write (`en_init`, `hit`, `addr_init`, `data_init`) with the boundary gap score k·GAP. It raises `busy` for the whole sweep and pulses `done` once at the end, which hands control to the cell-fill stage.

---
 rtl/score_init_if.sv | 30 +++
 rtl/score_init_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/score_init_if.sv
// score_init_if: handshake/bus bundle between the upstream controller and
// score_init_sequencer, and from the sequencer to the score-RAM write stage.
//   start, stall          : controller -> sequencer
//   en_init, hit          : write valid / row(0) vs column(1) select
//   addr_init             : boundary index k (AW bits)
//   data_init             : boundary score k*GAP (signed 9 bits)
//   busy, done            : sweep in progress / one-cycle completion pulse
// modport slave is the sequencer side, modport master the controller side.
interface score_init_if #(
    parameter int AW = 8
);
    logic                start;
    logic                stall;
    logic                en_init;
    logic                hit;
    logic [AW-1:0]       addr_init;
    logic signed [8:0]   data_init;
    logic                busy;
    logic                done;

    modport slave (
        input  start, stall,
        output en_init, hit, addr_init, data_init, busy, done
    );

    modport master (
        output start, stall,
        input  en_init, hit, addr_init, data_init, busy, done
    );
endinterface

// File: rtl/score_init_sequencer.sv
// score_init_sequencer: walks the first row (k=0..N) then the first column
// (k=1..N) of the (N+1)x(N+1) Needleman-Wunsch score matrix, emitting one
// registered boundary write per non-stalled cycle with score k*GAP built by
// an accumulator. busy covers the sweep; done pulses once at the end.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : score_init_if.slave (start, stall in; en_init, hit, addr_init,
//          data_init, busy, done out -- all outputs registered)
// Parameters: N (sequence length), GAP (signed 9-bit gap penalty),
//   BitAddr ($clog2(N+1)); bus AW must equal BitAddr+1.
// Build option: define SCORE_INIT_SAT_EN to saturate the score to
//   [-256, 255]; otherwise the 10-bit sum wraps to 9 bits.
module score_init_sequencer #(
    parameter int                N       = 128,
    parameter logic signed [8:0] GAP     = -9'sd2,
    parameter int                BitAddr = $clog2(N + 1)
) (
    input  logic        clk,
    input  logic        rst,
    score_init_if.slave bus
);
    localparam int AW = BitAddr + 1;
    localparam logic [AW-1:0] K_LAST = AW'(N);

    typedef enum logic [1:0] {IDLE, ROW, COL, FIN} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     k, k_nxt;
    logic signed [8:0] acc, acc_nxt;

    logic              en_q, hit_q, busy_q, done_q;
    logic [AW-1:0]     addr_q;
    logic signed [8:0] data_q;

    logic              en_nxt, hit_nxt, busy_nxt, done_nxt;
    logic [AW-1:0]     addr_nxt;
    logic signed [8:0] data_nxt;

    // One accumulator step: sum at 10-bit precision, then reduce to 9 bits.
    function automatic logic signed [8:0] add_gap(input logic signed [8:0] a);
        logic signed [9:0] sum;
        sum = {a[8], a} + {GAP[8], GAP};
`ifdef SCORE_INIT_SAT_EN
        if (sum < -10'sd256)
            return -9'sd256;
        else if (sum > 10'sd255)
            return 9'sd255;
        else
            return sum[8:0];
`else
        return sum[8:0];
`endif
    endfunction

    // k/acc always describe the next write to issue. Outputs are the
    // registered image of what this cycle decides, so a write decided in
    // IDLE (k=0) is visible right after the start edge.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        acc_nxt   = acc;
        en_nxt    = 1'b0;
        hit_nxt   = 1'b0;
        addr_nxt  = '0;
        data_nxt  = '0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    // cell (0,0): addr 0, score 0 -- defaults already zero
                    state_nxt = ROW;
                    en_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    k_nxt     = AW'(1);
                    acc_nxt   = add_gap(9'sd0);
                end
            end
            ROW, COL: begin
                busy_nxt = 1'b1;
                if (state == COL && k > K_LAST) begin
                    // Last column write is on the bus this cycle; the
                    // following cycle is FIN with the done pulse.
                    state_nxt = FIN;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else if (!bus.stall) begin
                    en_nxt   = 1'b1;
                    hit_nxt  = (state == COL);
                    addr_nxt = k;
                    data_nxt = acc;
                    if (state == ROW && k == K_LAST) begin
                        // column restarts at k=1: (0,0) belongs to the row
                        state_nxt = COL;
                        k_nxt     = AW'(1);
                        acc_nxt   = add_gap(9'sd0);
                    end else begin
                        k_nxt   = k + AW'(1);
                        acc_nxt = add_gap(acc);
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            acc    <= '0;
            en_q   <= 1'b0;
            hit_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            acc    <= acc_nxt;
            en_q   <= en_nxt;
            hit_q  <= hit_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.en_init   = en_q;
    assign bus.hit       = hit_q;
    assign bus.addr_init = addr_q;
    assign bus.data_init = data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
